// File: rtl/kbd_pkg.sv
// Shared PS/2 set-2 scancode constants and prefix-state type for the keyboard decoder.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } prefix_state_e;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

endpackage

// File: rtl/scancode_lut.sv
// Combinational set-2 scancode to ASCII lookup for the four caps/shift modes.
module scancode_lut
    import kbd_pkg::*;
(
    input  logic [7:0] addr,
    input  logic       caps,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] norm_c;
    logic [7:0] shift_c;

    always_comb begin
        norm_c  = 8'h00;
        shift_c = 8'h00;
        case (addr)
            8'h1C: norm_c = 8'h61;  8'h32: norm_c = 8'h62;  8'h21: norm_c = 8'h63;
            8'h23: norm_c = 8'h64;  8'h24: norm_c = 8'h65;  8'h2B: norm_c = 8'h66;
            8'h34: norm_c = 8'h67;  8'h33: norm_c = 8'h68;  8'h43: norm_c = 8'h69;
            8'h3B: norm_c = 8'h6A;  8'h42: norm_c = 8'h6B;  8'h4B: norm_c = 8'h6C;
            8'h3A: norm_c = 8'h6D;  8'h31: norm_c = 8'h6E;  8'h44: norm_c = 8'h6F;
            8'h4D: norm_c = 8'h70;  8'h15: norm_c = 8'h71;  8'h2D: norm_c = 8'h72;
            8'h1B: norm_c = 8'h73;  8'h2C: norm_c = 8'h74;  8'h3C: norm_c = 8'h75;
            8'h2A: norm_c = 8'h76;  8'h1D: norm_c = 8'h77;  8'h22: norm_c = 8'h78;
            8'h35: norm_c = 8'h79;  8'h1A: norm_c = 8'h7A;
            8'h45: begin norm_c = 8'h30; shift_c = 8'h29; end
            8'h16: begin norm_c = 8'h31; shift_c = 8'h21; end
            8'h1E: begin norm_c = 8'h32; shift_c = 8'h40; end
            8'h26: begin norm_c = 8'h33; shift_c = 8'h23; end
            8'h25: begin norm_c = 8'h34; shift_c = 8'h24; end
            8'h2E: begin norm_c = 8'h35; shift_c = 8'h25; end
            8'h36: begin norm_c = 8'h36; shift_c = 8'h5E; end
            8'h3D: begin norm_c = 8'h37; shift_c = 8'h26; end
            8'h3E: begin norm_c = 8'h38; shift_c = 8'h2A; end
            8'h46: begin norm_c = 8'h39; shift_c = 8'h28; end
            8'h4E: begin norm_c = 8'h2D; shift_c = 8'h5F; end
            8'h55: begin norm_c = 8'h3D; shift_c = 8'h2B; end
            8'h54: begin norm_c = 8'h5B; shift_c = 8'h7B; end
            8'h5B: begin norm_c = 8'h5D; shift_c = 8'h7D; end
            8'h5D: begin norm_c = 8'h5C; shift_c = 8'h7C; end
            8'h4C: begin norm_c = 8'h3B; shift_c = 8'h3A; end
            8'h52: begin norm_c = 8'h27; shift_c = 8'h22; end
            8'h41: begin norm_c = 8'h2C; shift_c = 8'h3C; end
            8'h49: begin norm_c = 8'h2E; shift_c = 8'h3E; end
            8'h4A: begin norm_c = 8'h2F; shift_c = 8'h3F; end
            8'h0E: begin norm_c = 8'h60; shift_c = 8'h7E; end
            8'h29: begin norm_c = 8'h20; shift_c = 8'h20; end
            8'h5A: begin norm_c = 8'h0D; shift_c = 8'h0D; end
            8'h66: begin norm_c = 8'h08; shift_c = 8'h08; end
            8'h0D: begin norm_c = 8'h09; shift_c = 8'h09; end
            8'h76: begin norm_c = 8'h1B; shift_c = 8'h1B; end
            default: ;
        endcase
        // Letters flip case on caps XOR shift; everything else follows shift only.
        if (is_letter(norm_c)) begin
            ascii = (caps ^ shift) ? (norm_c & 8'hDF) : norm_c;
        end else begin
            ascii = shift ? shift_c : norm_c;
        end
    end

endmodule

// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 scancode stream to buffered ASCII: prefix FSM, modifier tracking and character FIFO.
module kbd_ascii_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter bit          ENABLE_CTRL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_code,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [7:0]                    ascii,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic                          caps_led
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    prefix_state_e state_q, state_d;
    logic lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
    logic caps_q, caps_d, caps_held_q, caps_held_d;
    logic ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [7:0] mem_d [FIFO_DEPTH];

    logic [7:0] lut_ascii;
    logic [7:0] char_code;
    logic       char_valid;
    logic       is_make, is_ext;
    logic       push, pop, full;

    scancode_lut u_lut (
        .addr  (scan_code),
        .caps  (caps_q),
        .shift (lshift_q | rshift_q),
        .ascii (lut_ascii)
    );

    always_comb begin
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        ctrl_d      = ctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        char_valid  = 1'b0;
        char_code   = 8'h00;
        is_make     = (state_q == ST_IDLE) || (state_q == ST_EXT);
        is_ext      = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        if (scan_valid) begin
            if (scan_code == SC_EXT) begin
                state_d = ST_EXT;
            end else if (scan_code == SC_BREAK) begin
                state_d = is_ext ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                if (scan_code == SC_CTRL) begin
                    ctrl_d = is_make;
                end else if (!is_ext) begin
                    case (scan_code)
                        SC_LSHIFT: lshift_d = is_make;
                        SC_RSHIFT: rshift_d = is_make;
                        SC_CAPS: begin
                            // Held flag suppresses re-toggling on typematic repeats.
                            if (is_make && !caps_held_q) caps_d = ~caps_q;
                            caps_held_d = is_make;
                        end
                        default: begin
                            if (is_make && (lut_ascii != 8'h00)) begin
                                char_valid = 1'b1;
                                char_code  = (ENABLE_CTRL && ctrl_q && is_letter(lut_ascii))
                                             ? (lut_ascii & 8'h1F) : lut_ascii;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        full     = (count_q == DEPTH_C);
        pop      = out_ready && (count_q != '0);
        push     = char_valid && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = (ovf_q && !clr_ovf) || (char_valid && !push);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = char_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_q      <= ctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid  = (count_q != '0);
    assign ascii      = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign caps_led   = caps_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Scoreboard bench: expected characters are queued as scancodes are sent and compared on drain.
module tb_kbd_ascii_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] ascii;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       clr_ovf;
    logic       caps_led;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    kbd_ascii_decoder #(.FIFO_DEPTH(16), .ENABLE_CTRL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .ascii      (ascii),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .caps_led   (caps_led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic expect_char(input logic [7:0] c);
        exp_q.push_back(c);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 64 && (out_valid || exp_q.size() > 0); i++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) check({tag, "_extra"}, ascii, 32'hFFFF_FFFF);
                else check(tag, ascii, exp_q.pop_front());
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({tag, "_missing"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_empty"}, fifo_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ascii", ascii, 8'h00);
        check("rst_ovf", overflow, 0);
        check("rst_caps", caps_led, 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain make, then a break that must not push.
        send(8'h1C); expect_char(8'h61);
        check("make_valid", out_valid, 1);
        check("make_count", fifo_count, 1);
        send(8'hF0); send(8'h1C);
        check("break_count", fifo_count, 1);
        drain("plain");

        // Shift handling.
        send(8'h12); send(8'h1C); expect_char(8'h41);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h16); expect_char(8'h31);
        send(8'h12); send(8'h16); expect_char(8'h21);
        send(8'hF0); send(8'h12);
        drain("shift");

        // Caps lock with typematic repeats.
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        check("caps_on", caps_led, 1);
        check("caps_nopush", fifo_count, 0);
        send(8'h1C); expect_char(8'h41);
        send(8'h12); send(8'h1C); expect_char(8'h61);
        send(8'hF0); send(8'h12);
        drain("caps");
        send(8'h58); send(8'hF0); send(8'h58);
        check("caps_off", caps_led, 0);

        // Ctrl (plain and extended) and a non-ctrl extended key.
        send(8'h14); send(8'h1C); expect_char(8'h01);
        send(8'hF0); send(8'h14);
        send(8'hE0); send(8'h14); send(8'h21); expect_char(8'h03);
        send(8'hE0); send(8'hF0); send(8'h14);
        send(8'h2D); expect_char(8'h72);
        drain("ctrl");
        send(8'hE0); send(8'h75);
        check("ext_nopush", fifo_count, 0);
        send(8'h1C); expect_char(8'h61);
        drain("ext_idle");

        // FIFO full and overflow.
        for (int i = 0; i < 17; i++) begin
            send(8'h1C);
            if (i < 16) expect_char(8'h61);
        end
        check("full_count", fifo_count, 16);
        check("full_ovf", overflow, 1);
        check("full_ascii", ascii, 8'h61);
        send(8'h1C);
        check("full_drop_count", fifo_count, 16);
        // Pop and push in the same cycle while full.
        out_ready = 1'b1;
        check("popush_head", ascii, exp_q.pop_front());
        expect_char(8'h62);
        send(8'h32);
        out_ready = 1'b0;
        check("popush_count", fifo_count, 16);
        check("popush_ovf", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_ovf", overflow, 0);
        drain("full");

        // Reset in the middle of a break prefix with caps on and data queued.
        send(8'h58); send(8'hF0); send(8'h58);
        send(8'h1C);
        check("pre_rst_ascii", ascii, 8'h41);
        send(8'hF0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ascii", ascii, 8'h00);
        check("mid_rst_caps", caps_led, 0);
        check("mid_rst_ovf", overflow, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h1C); expect_char(8'h61);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
